// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared constants for the memory-mapped interval timer: register offsets
// within a channel's window, CTRL bit positions and the STATUS pending bit.
// -----------------------------------------------------------------------------
package timer_pkg;

    // Register offsets (low two address bits)
    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_COMPARE = 2'd1;
    localparam logic [1:0] REG_COUNT   = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    // CTRL bit indices and implemented width
    localparam int CTRL_EN = 0;
    localparam int CTRL_AR = 1;
    localparam int CTRL_IE = 2;
    localparam int CTRL_W  = 3;

    // STATUS bit index of the sticky pending flag
    localparam int STAT_PEND = 0;

endpackage

// File: rtl/timer_channel.sv
// -----------------------------------------------------------------------------
// timer_channel
// One timer channel: CTRL, COMPARE, COUNT and a sticky pending flag.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   tick              one-cycle prescaler pulse
//   wr_ctrl/compare/count/status  per-register write strobes
//   data_in           write data
//   ctrl, compare, count, pending  current register state (readback)
//   irq               pending & IE
// -----------------------------------------------------------------------------
module timer_channel
    import timer_pkg::*;
#(
    parameter int WIDTH = 32
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              wr_ctrl,
    input  logic              wr_compare,
    input  logic              wr_count,
    input  logic              wr_status,
    input  logic [WIDTH-1:0]  data_in,
    output logic [CTRL_W-1:0] ctrl,
    output logic [WIDTH-1:0]  compare,
    output logic [WIDTH-1:0]  count,
    output logic              pending,
    output logic              irq
);

    logic [CTRL_W-1:0] ctrl_r;
    logic [WIDTH-1:0]  compare_r;
    logic [WIDTH-1:0]  count_r;
    logic              pending_r;
    logic [WIDTH-1:0]  nxt_s;
    logic              step_s;
    logic              match_s;

    // Increment candidate and match detect; the match always uses the
    // COMPARE value held before this edge, so a same-cycle COMPARE write
    // only affects the following tick.
    always_comb begin
        nxt_s   = count_r + WIDTH'(1'b1);
        step_s  = tick & ctrl_r[CTRL_EN];
        match_s = step_s & (nxt_s == compare_r);
    end

    // CTRL: CPU write wins over the one-shot EN drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_r <= {CTRL_W{1'b0}};
        end else if (wr_ctrl) begin
            ctrl_r <= data_in[CTRL_W-1:0];
        end else if (match_s && !ctrl_r[CTRL_AR]) begin
            ctrl_r[CTRL_EN] <= 1'b0;
        end
    end

    // COMPARE: software-owned only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            compare_r <= {WIDTH{1'b0}};
        end else if (wr_compare) begin
            compare_r <= data_in;
        end
    end

    // COUNT: CPU write wins; auto-reload returns to zero, one-shot parks on
    // the match value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {WIDTH{1'b0}};
        end else if (wr_count) begin
            count_r <= data_in;
        end else if (match_s && ctrl_r[CTRL_AR]) begin
            count_r <= {WIDTH{1'b0}};
        end else if (step_s) begin
            count_r <= nxt_s;
        end
    end

    // Pending: a hardware set beats a same-cycle write-1-to-clear so no
    // interrupt is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_r <= 1'b0;
        end else if (match_s) begin
            pending_r <= 1'b1;
        end else if (wr_status && data_in[STAT_PEND]) begin
            pending_r <= 1'b0;
        end
    end

    assign ctrl    = ctrl_r;
    assign compare = compare_r;
    assign count   = count_r;
    assign pending = pending_r;
    assign irq     = pending_r & ctrl_r[CTRL_IE];

endmodule

// File: rtl/mmio_timer.sv
// -----------------------------------------------------------------------------
// mmio_timer
// Multi-channel memory-mapped interval timer with a shared prescaler.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   we         register write strobe
//   addr       {channel, reg}; reg 0=CTRL 1=COMPARE 2=COUNT 3=STATUS
//   data_in    write data
//   data_out   combinational readback of the addressed register
//   irq        per-channel interrupt (pending & IE)
//   INT        OR of all irq lines
// -----------------------------------------------------------------------------
module mmio_timer
    import timer_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int NCH      = 2,
    parameter int PRESCALE = 100000,
    parameter int CH_W     = 3
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [CH_W+1:0]   addr,
    input  logic [WIDTH-1:0]  data_in,
    output logic [WIDTH-1:0]  data_out,
    output logic [NCH-1:0]    irq,
    output logic              INT
);

    localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0]  ps_r;
    logic             tick_s;
    logic [CH_W-1:0]  ch_sel_s;
    logic [1:0]       reg_sel_s;
    logic [WIDTH-1:0] rd_word_s [NCH];

    assign ch_sel_s  = addr[CH_W+1:2];
    assign reg_sel_s = addr[1:0];
    assign tick_s    = (ps_r == PS_LAST);

    // Free-running prescaler 0..PRESCALE-1; with PRESCALE=1 it stays at 0
    // and tick is high every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps_r <= {PS_W{1'b0}};
        end else if (tick_s) begin
            ps_r <= {PS_W{1'b0}};
        end else begin
            ps_r <= ps_r + PS_W'(1'b1);
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic              sel_s;
        logic [CTRL_W-1:0] ctrl_s;
        logic [WIDTH-1:0]  compare_s;
        logic [WIDTH-1:0]  count_s;
        logic              pending_s;

        assign sel_s = we && (ch_sel_s == CH_W'(i));

        timer_channel #(.WIDTH(WIDTH)) u_ch (
            .clk        (clk),
            .rst        (rst),
            .tick       (tick_s),
            .wr_ctrl    (sel_s && (reg_sel_s == REG_CTRL)),
            .wr_compare (sel_s && (reg_sel_s == REG_COMPARE)),
            .wr_count   (sel_s && (reg_sel_s == REG_COUNT)),
            .wr_status  (sel_s && (reg_sel_s == REG_STATUS)),
            .data_in    (data_in),
            .ctrl       (ctrl_s),
            .compare    (compare_s),
            .count      (count_s),
            .pending    (pending_s),
            .irq        (irq[i])
        );

        // Per-channel readback word for the addressed register.
        always_comb begin
            rd_word_s[i] = {WIDTH{1'b0}};
            case (reg_sel_s)
                REG_CTRL:    rd_word_s[i] = {{(WIDTH-CTRL_W){1'b0}}, ctrl_s};
                REG_COMPARE: rd_word_s[i] = compare_s;
                REG_COUNT:   rd_word_s[i] = count_s;
                REG_STATUS:  rd_word_s[i] = {{(WIDTH-1){1'b0}}, pending_s};
                default:     rd_word_s[i] = {WIDTH{1'b0}};
            endcase
        end
    end

    // Read mux: at most one channel index matches; unimplemented channel
    // indices fall through to zero.
    always_comb begin
        data_out = {WIDTH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            data_out = data_out |
                       ((ch_sel_s == CH_W'(i)) ? rd_word_s[i] : {WIDTH{1'b0}});
        end
    end

    assign INT = |irq;

endmodule

// File: tb/tb_mmio_timer.sv
// -----------------------------------------------------------------------------
// tb_mmio_timer
// Self-checking bench for mmio_timer (PRESCALE=4, NCH=2). Directed scenarios
// plus a randomized register-traffic run checked against a behavioural model.
// -----------------------------------------------------------------------------
module tb_mmio_timer;

    localparam int WIDTH    = 32;
    localparam int NCH      = 2;
    localparam int PRESCALE = 4;
    localparam int CH_W     = 3;

    logic             clk     = 1'b0;
    logic             rst     = 1'b1;
    logic             we      = 1'b0;
    logic [CH_W+1:0]  addr    = '0;
    logic [WIDTH-1:0] data_in = '0;
    logic [WIDTH-1:0] data_out;
    logic [NCH-1:0]   irq;
    logic             INT;

    int vectors     = 0;
    int miscompares = 0;

    mmio_timer #(
        .WIDTH(WIDTH), .NCH(NCH), .PRESCALE(PRESCALE), .CH_W(CH_W)
    ) dut (
        .clk(clk), .rst(rst), .we(we), .addr(addr), .data_in(data_in),
        .data_out(data_out), .irq(irq), .INT(INT)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    int unsigned      m_edges;
    logic [2:0]       m_ctrl [NCH];
    logic [WIDTH-1:0] m_cmp  [NCH];
    logic [WIDTH-1:0] m_cnt  [NCH];
    logic             m_pend [NCH];

    function automatic void model_reset();
        m_edges = 0;
        for (int i = 0; i < NCH; i++) begin
            m_ctrl[i] = 3'd0;
            m_cmp[i]  = 32'd0;
            m_cnt[i]  = 32'd0;
            m_pend[i] = 1'b0;
        end
    endfunction

    // One clock edge: tick on every PRESCALE-th edge after reset release.
    function automatic void model_edge();
        bit tick;
        tick    = ((m_edges % PRESCALE) == (PRESCALE - 1));
        m_edges = m_edges + 1;
        for (int i = 0; i < NCH; i++) begin
            bit               sel;
            bit               hit;
            logic [WIDTH-1:0] nxt;
            logic [WIDTH-1:0] cnt_n;
            logic [2:0]       ctrl_n;
            logic             pend_n;
            sel    = we && (int'(addr[CH_W+1:2]) == i);
            hit    = 1'b0;
            cnt_n  = m_cnt[i];
            ctrl_n = m_ctrl[i];
            pend_n = m_pend[i];
            if (tick && m_ctrl[i][0]) begin
                nxt = m_cnt[i] + 32'd1;
                if (nxt == m_cmp[i]) begin
                    hit = 1'b1;
                    if (m_ctrl[i][1]) cnt_n = 32'd0;
                    else begin
                        cnt_n     = nxt;
                        ctrl_n[0] = 1'b0;
                    end
                end else begin
                    cnt_n = nxt;
                end
            end
            if (sel && addr[1:0] == 2'd0) ctrl_n = data_in[2:0];
            if (sel && addr[1:0] == 2'd2) cnt_n = data_in;
            if (hit) pend_n = 1'b1;
            else if (sel && addr[1:0] == 2'd3 && data_in[0]) pend_n = 1'b0;
            if (sel && addr[1:0] == 2'd1) m_cmp[i] = data_in;
            m_cnt[i]  = cnt_n;
            m_ctrl[i] = ctrl_n;
            m_pend[i] = pend_n;
        end
    endfunction

    function automatic logic [WIDTH-1:0] model_read(input logic [CH_W+1:0] a);
        int ch;
        ch = int'(a[CH_W+1:2]);
        model_read = 32'd0;
        if (ch < NCH) begin
            case (a[1:0])
                2'd0:    model_read = {29'd0, m_ctrl[ch]};
                2'd1:    model_read = m_cmp[ch];
                2'd2:    model_read = m_cnt[ch];
                default: model_read = {31'd0, m_pend[ch]};
            endcase
        end
    endfunction

    function automatic logic [NCH-1:0] model_irq();
        for (int i = 0; i < NCH; i++) model_irq[i] = m_pend[i] & m_ctrl[i][2];
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_edge();
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [CH_W+1:0] ra(input int ch, input int r);
        ra = {CH_W'(ch), 2'(r)};
    endfunction

    task automatic wr(input logic [CH_W+1:0] a, input logic [WIDTH-1:0] d);
        addr = a; data_in = d; we = 1'b1;
        @(posedge clk); #1;
        we = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [CH_W+1:0] a);
        addr = a; #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        we = 1'b0; rst = 1'b1; #1;
        rst = 1'b0; #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        for (int c = 0; c < NCH; c++) begin
            for (int r = 0; r < 4; r++) begin
                rd(ra(c, r));
                vectors++;
                if (data_out !== 32'd0) begin
                    miscompares++;
                    $display("FAIL reset_regs ch%0d reg%0d: got %0h expected 0", c, r, data_out);
                end
            end
        end
        vectors++;
        if (irq !== 2'b00 || INT !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_irq: got irq=%b INT=%b expected 00/0", irq, INT);
        end
        // Run ch0 into an interrupt, then reset between edges.
        wr(ra(0, 1), 32'd2);
        wr(ra(0, 0), 32'd7);
        idle(13);
        vectors++;
        if (irq[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_irq: got %b expected 1", irq[0]);
        end
        @(negedge clk);
        addr = ra(0, 2);
        rst  = 1'b1; #1;
        vectors++;
        if (irq !== 2'b00 || INT !== 1'b0 || data_out !== 32'd0) begin
            miscompares++;
            $display("FAIL mid_reset: got irq=%b INT=%b count=%0h expected 00/0/0", irq, INT, data_out);
        end
        rst = 1'b0; #1;
        idle(10);
        rd(ra(0, 2));
        vectors++;
        if (data_out !== 32'd0) begin
            miscompares++;
            $display("FAIL post_reset_count: got %0h expected 0", data_out);
        end
        rd(ra(0, 0));
        vectors++;
        if (data_out !== 32'd0) begin
            miscompares++;
            $display("FAIL post_reset_ctrl: got %0h expected 0", data_out);
        end
    endtask

    task automatic test_autoreload();
        logic [WIDTH-1:0] seq [3];
        seq[0] = 32'd1; seq[1] = 32'd2; seq[2] = 32'd0;
        pulse_reset();
        wr(ra(0, 1), 32'd3);         // edge 0
        idle(2);                     // edges 1,2
        wr(ra(0, 0), 32'd7);         // edge 3 (tick, EN still 0)
        idle(11);                    // edge 14
        vectors++;
        if (irq[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL ar_early_irq: got %b expected 0", irq[0]);
        end
        idle(1);                     // edge 15: 12 cycles after enable
        vectors++;
        if (irq[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL ar_irq_12: got %b expected 1", irq[0]);
        end
        for (int k = 0; k < 3; k++) begin
            idle(4);
            rd(ra(0, 2));
            vectors++;
            if (data_out !== seq[k]) begin
                miscompares++;
                $display("FAIL ar_count_seq[%0d]: got %0h expected %0h", k, data_out, seq[k]);
            end
            rd(ra(0, 3));
            vectors++;
            if (data_out !== 32'd1) begin
                miscompares++;
                $display("FAIL ar_pending_sticky[%0d]: got %0h expected 1", k, data_out);
            end
        end
        wr(ra(0, 3), 32'd1);         // edge 28
        vectors++;
        if (irq[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL ar_w1c: got %b expected 0", irq[0]);
        end
        idle(10);                    // edge 38
        vectors++;
        if (irq[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL ar_reassert_early: got %b expected 0", irq[0]);
        end
        idle(1);                     // edge 39
        vectors++;
        if (irq[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL ar_reassert: got %b expected 1", irq[0]);
        end
    endtask

    task automatic test_oneshot();
        pulse_reset();
        wr(ra(1, 1), 32'd2);         // edge 0
        idle(2);
        wr(ra(1, 0), 32'd5);         // edge 3
        idle(7);                     // edge 10
        vectors++;
        if (irq[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL os_early_irq: got %b expected 0", irq[1]);
        end
        idle(1);                     // edge 11
        for (int pass = 0; pass < 2; pass++) begin
            vectors++;
            if (irq !== 2'b10) begin
                miscompares++;
                $display("FAIL os_irq[%0d]: got %b expected 10", pass, irq);
            end
            rd(ra(1, 2));
            vectors++;
            if (data_out !== 32'd2) begin
                miscompares++;
                $display("FAIL os_count_hold[%0d]: got %0h expected 2", pass, data_out);
            end
            rd(ra(1, 0));
            vectors++;
            if (data_out !== 32'd4) begin
                miscompares++;
                $display("FAIL os_ctrl[%0d]: got %0h expected 4", pass, data_out);
            end
            idle(40);
        end
    endtask

    task automatic test_mask_int();
        pulse_reset();
        wr(ra(0, 1), 32'd1);
        wr(ra(0, 0), 32'd3);         // EN|AR, IE off
        idle(8);
        rd(ra(0, 3));
        vectors++;
        if (data_out !== 32'd1 || irq !== 2'b00 || INT !== 1'b0) begin
            miscompares++;
            $display("FAIL mask_ie0: got status=%0h irq=%b INT=%b expected 1/00/0", data_out, irq, INT);
        end
        wr(ra(0, 0), 32'd7);
        vectors++;
        if (irq !== 2'b01 || INT !== 1'b1) begin
            miscompares++;
            $display("FAIL mask_ie1: got irq=%b INT=%b expected 01/1", irq, INT);
        end
        wr(ra(0, 0), 32'd4);         // stop ch0, keep IE
        wr(ra(1, 1), 32'd1);
        wr(ra(1, 0), 32'd5);
        idle(4);
        vectors++;
        if (irq !== 2'b11 || INT !== 1'b1) begin
            miscompares++;
            $display("FAIL mask_both: got irq=%b INT=%b expected 11/1", irq, INT);
        end
        wr(ra(1, 0), 32'd0);         // mask ch1 without clearing pending
        rd(ra(1, 3));
        vectors++;
        if (irq !== 2'b01 || data_out !== 32'd1) begin
            miscompares++;
            $display("FAIL mask_keep_pend: got irq=%b status1=%0h expected 01/1", irq, data_out);
        end
        wr(ra(1, 0), 32'd4);
        wr(ra(0, 3), 32'd1);
        vectors++;
        if (irq !== 2'b10 || INT !== 1'b1) begin
            miscompares++;
            $display("FAIL int_one_left: got irq=%b INT=%b expected 10/1", irq, INT);
        end
        wr(ra(1, 3), 32'd1);
        vectors++;
        if (irq !== 2'b00 || INT !== 1'b0) begin
            miscompares++;
            $display("FAIL int_cleared: got irq=%b INT=%b expected 00/0", irq, INT);
        end
    endtask

    task automatic test_collision();
        pulse_reset();
        wr(ra(0, 1), 32'd1);         // edge 0
        idle(2);
        wr(ra(0, 0), 32'd7);         // edge 3
        idle(3);                     // edge 6
        wr(ra(0, 3), 32'd1);         // edge 7: first match tick
        rd(ra(0, 3));
        vectors++;
        if (data_out !== 32'd1 || irq[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL coll_w1c_first: got status=%0h irq0=%b expected 1/1", data_out, irq[0]);
        end
        idle(3);                     // edge 10
        wr(ra(0, 3), 32'd1);         // edge 11: match tick again
        rd(ra(0, 3));
        vectors++;
        if (data_out !== 32'd1) begin
            miscompares++;
            $display("FAIL coll_w1c_again: got %0h expected 1", data_out);
        end
        wr(ra(0, 1), 32'd100);       // edge 12
        idle(2);
        wr(ra(0, 2), 32'd7);         // edge 15: tick
        rd(ra(0, 2));
        vectors++;
        if (data_out !== 32'd7) begin
            miscompares++;
            $display("FAIL coll_count_write: got %0h expected 7", data_out);
        end
        idle(4);                     // edge 19
        rd(ra(0, 2));
        vectors++;
        if (data_out !== 32'd8) begin
            miscompares++;
            $display("FAIL coll_count_next: got %0h expected 8", data_out);
        end
        wr(ra(0, 3), 32'd1);         // edge 20
        idle(2);
        wr(ra(0, 1), 32'd9);         // edge 23: tick compares against 100
        rd(ra(0, 3));
        vectors++;
        if (data_out !== 32'd0) begin
            miscompares++;
            $display("FAIL coll_compare_old: got status %0h expected 0", data_out);
        end
        rd(ra(0, 2));
        vectors++;
        if (data_out !== 32'd9) begin
            miscompares++;
            $display("FAIL coll_compare_count: got %0h expected 9", data_out);
        end
    endtask

    task automatic test_wrap_bounds();
        logic [WIDTH-1:0] exp_regs [8];
        pulse_reset();
        wr(ra(0, 2), 32'hFFFF_FFFF); // edge 0
        wr(ra(0, 1), 32'd0);         // edge 1
        idle(1);
        wr(ra(0, 0), 32'd5);         // edge 3
        rd(ra(0, 2));
        vectors++;
        if (data_out !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL wrap_preload: got %0h expected ffffffff", data_out);
        end
        idle(4);                     // edge 7: wrap match
        vectors++;
        if (irq[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_irq: got %b expected 1", irq[0]);
        end
        for (int r = 0; r < 4; r++) wr(ra(5, r), 32'hFFFF_FFFF);
        for (int r = 0; r < 4; r++) begin
            rd(ra(5, r));
            vectors++;
            if (data_out !== 32'd0) begin
                miscompares++;
                $display("FAIL bounds_read reg%0d: got %0h expected 0", r, data_out);
            end
        end
        exp_regs[0] = 32'd4; exp_regs[1] = 32'd0; exp_regs[2] = 32'd0; exp_regs[3] = 32'd1;
        exp_regs[4] = 32'd0; exp_regs[5] = 32'd0; exp_regs[6] = 32'd0; exp_regs[7] = 32'd0;
        for (int k = 0; k < 8; k++) begin
            rd(ra(k / 4, k % 4));
            vectors++;
            if (data_out !== exp_regs[k]) begin
                miscompares++;
                $display("FAIL bounds_state ch%0d reg%0d: got %0h expected %0h", k / 4, k % 4, data_out, exp_regs[k]);
            end
        end
    endtask

    task automatic test_random();
        pulse_reset();
        for (int n = 0; n < 3000; n++) begin
            int               ch;
            int               r;
            logic [WIDTH-1:0] d;
            ch = ($urandom_range(0, 7) == 0) ? int'($urandom_range(2, 7)) : int'($urandom_range(0, NCH - 1));
            r  = int'($urandom_range(0, 3));
            case (r)
                0:       d = 32'($urandom_range(0, 7));
                1:       d = 32'($urandom_range(0, 5));
                2:       d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE + 32'($urandom_range(0, 1))
                                                         : 32'($urandom_range(0, 6));
                default: d = 32'($urandom_range(0, 1));
            endcase
            addr    = ra(ch, r);
            data_in = d;
            we      = ($urandom_range(0, 3) == 0);
            @(posedge clk); #1;
            we = 1'b0;
            vectors++;
            if (irq !== model_irq()) begin
                miscompares++;
                $display("FAIL rand_irq n=%0d: got %b expected %b", n, irq, model_irq());
            end
            vectors++;
            if (INT !== (|model_irq())) begin
                miscompares++;
                $display("FAIL rand_int n=%0d: got %b expected %b", n, INT, |model_irq());
            end
            rd(ra(int'($urandom_range(0, 7)), int'($urandom_range(0, 3))));
            vectors++;
            if (data_out !== model_read(addr)) begin
                miscompares++;
                $display("FAIL rand_read n=%0d addr=%0h: got %0h expected %0h", n, addr, data_out, model_read(addr));
            end
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        test_reset();
        test_autoreload();
        test_oneshot();
        test_mask_int();
        test_collision();
        test_wrap_bounds();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
